// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
//   Bundles the scanned 7-segment input lines and the recovered-frame outputs
//   of seg7_scan_decoder.
//   Signals:
//     seg_in    [7:0]        {A,B,C,D,E,F,G,DP}, bit7 = A, bit0 = DP
//     an_in     [NDIG-1:0]   one-hot digit enables, bit0 = digit 0
//     bcd_out   [4*NDIG-1:0] published digits, digit i at [4i+3:4i]
//     dp_out    [NDIG-1:0]   published decimal points
//     valid                  one-cycle pulse when published outputs change
//     digit_err [NDIG-1:0]   published glyph was not decodable
//     frame_cnt [7:0]        count of published frames, wraps
//   Modports: master = display side / stimulus, slave = decoder.
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic [7:0]        seg_in;
  logic [NDIG-1:0]   an_in;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   dp_out;
  logic              valid;
  logic [NDIG-1:0]   digit_err;
  logic [7:0]        frame_cnt;

  modport master (
    output seg_in, an_in,
    input  bcd_out, dp_out, valid, digit_err, frame_cnt
  );

  modport slave (
    input  seg_in, an_in,
    output bcd_out, dp_out, valid, digit_err, frame_cnt
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//   Receives the seg/anode lines of a multiplexed 7-segment display, waits for
//   each digit slot to settle, decodes the glyph to BCD and assembles frames.
//   A frame is published only after STABLE_SCANS consecutive identical frames,
//   and only when it differs from what is currently published.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous reset, active low
//     bus    seg7_scan_decoder_if.slave (seg_in/an_in in, frame outputs out)
//   Parameters: NDIG (1..8), SETTLE_CYC (>=1), STABLE_SCANS (>=1)
//   Build option: define SEG7_SCAN_ACTIVE_LOW_EN to invert seg_in and an_in
//   right after the synchronizer (common-anode boards).
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int NDIG         = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int STABLE_SCANS = 2
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  // Frame layout: {bcd[4*NDIG], dp[NDIG], err[NDIG]}
  localparam int FW = 6 * NDIG;
  localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(STABLE_SCANS);
  localparam logic [FW-1:0] OUT_RST     = {{NDIG{4'hF}}, {(2*NDIG){1'b0}}};

  // Returns {err, bcd}; blank maps to F without error.
  function automatic logic [4:0] decode7(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b0000000: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  logic [7:0]      seg_s1_q, seg_s2_q, seg_prev_q, seg_v;
  logic [NDIG-1:0] an_s1_q, an_s2_q, an_prev_q, an_v;

`ifdef SEG7_SCAN_ACTIVE_LOW_EN
  assign seg_v = ~seg_s2_q;
  assign an_v  = ~an_s2_q;
`else
  assign seg_v = seg_s2_q;
  assign an_v  = an_s2_q;
`endif

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            taken_q, taken_d;
  logic [NDIG-1:0] seen_q, seen_d;
  logic [FW-1:0]   cand_q, cand_d, last_q, last_d, out_q, out_d;
  logic            have_last_q, have_last_d;
  logic [MW-1:0]   match_q, match_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;
  logic [7:0]      fcnt_q, fcnt_d;

  logic            chg, an_chg, onehot, sample, frame_end;
  logic [4:0]      dec;

  assign dec = decode7(seg_v[7:1]);

  always_comb begin
    an_chg = (an_v != an_prev_q);
    chg    = an_chg || (seg_v != seg_prev_q);
    onehot = (an_v != '0) && ((an_v & (an_v - NDIG'(1))) == '0);

    // Settle: one sample per anode slot, after SETTLE_CYC clean cycles.
    cnt_d   = cnt_q;
    taken_d = an_chg ? 1'b0 : taken_q;
    sample  = 1'b0;
    if (!onehot || chg) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_MAX) begin
      cnt_d  = cnt_q + CW'(1);
      sample = (cnt_q == SETTLE_LAST) && !taken_q;
    end
    if (sample) taken_d = 1'b1;

    // Candidate frame assembly.
    cand_d = cand_q;
    seen_d = seen_q;
    if (sample) begin
      for (int i = 0; i < NDIG; i++) begin
        if (an_v[i]) begin
          cand_d[2*NDIG + 4*i +: 4] = dec[3:0];
          cand_d[NDIG + i]          = seg_v[0];
          cand_d[i]                 = dec[4];
          seen_d[i]                 = 1'b1;
        end
      end
    end
    frame_end = sample && (&seen_d);

    // Stability tracking across consecutive frames.
    last_d      = last_q;
    have_last_d = have_last_q;
    match_d     = match_q;
    pend_d      = 1'b0;
    if (frame_end) begin
      if (have_last_q && (cand_d == last_q))
        match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
      else
        match_d = MW'(1);
      last_d      = cand_d;
      have_last_d = 1'b1;
      seen_d      = '0;
      pend_d      = (match_d == MATCH_MAX);
    end

    // Publish the stable frame one cycle later, only if it is new.
    out_d   = out_q;
    valid_d = 1'b0;
    fcnt_d  = fcnt_q;
    if (pend_q && (last_q != out_q)) begin
      out_d   = last_q;
      valid_d = 1'b1;
      fcnt_d  = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    seg_s1_q   <= bus.seg_in;
    seg_s2_q   <= seg_s1_q;
    an_s1_q    <= bus.an_in;
    an_s2_q    <= an_s1_q;
    seg_prev_q <= seg_v;
    an_prev_q  <= an_v;
    if (!rst_n) begin
      cnt_q       <= '0;
      taken_q     <= 1'b0;
      seen_q      <= '0;
      cand_q      <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      match_q     <= '0;
      pend_q      <= 1'b0;
      out_q       <= OUT_RST;
      valid_q     <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      taken_q     <= taken_d;
      seen_q      <= seen_d;
      cand_q      <= cand_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      match_q     <= match_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign bus.bcd_out   = out_q[FW-1 -: 4*NDIG];
  assign bus.dp_out    = out_q[2*NDIG-1 -: NDIG];
  assign bus.digit_err = out_q[NDIG-1:0];
  assign bus.valid     = valid_q;
  assign bus.frame_cnt = fcnt_q;

endmodule
